// File: rtl/tcp_rx_read_scheduler.sv
// Turns TCP RX notifications into credit-limited read-package requests, each paired
// with a metadata word; long notifications are split into MAX_READ_BYTES chunks.
module tcp_rx_read_scheduler #(
   parameter int unsigned MAX_READ_BYTES  = 1024,
   parameter int unsigned MAX_OUTSTANDING = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        event_valid,
   output logic        event_ready,
   input  logic [87:0] event_data,
   output logic        readreq_valid,
   input  logic        readreq_ready,
   output logic [31:0] readreq_data,
   output logic        meta_valid,
   input  logic        meta_ready,
   output logic [63:0] meta_data,
   input  logic        rx_done,
   output logic [7:0]  outstanding,
   output logic [15:0] dropped_cnt
);

   localparam logic [15:0] MAX_CHUNK = 16'(MAX_READ_BYTES);
   localparam logic [7:0]  MAX_OUT   = 8'(MAX_OUTSTANDING);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_ISSUE = 2'd2,
      S_WAIT  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] session_q, session_d;
   logic [31:0] ip_q, ip_d;
   logic [15:0] remaining_q, remaining_d;
   logic [15:0] chunk_q, chunk_d;
   logic        readreq_valid_q, readreq_valid_d;
   logic        meta_valid_q, meta_valid_d;
   logic [31:0] readreq_data_q, readreq_data_d;
   logic [63:0] meta_data_q, meta_data_d;
   logic [7:0]  outstanding_q, outstanding_d;
   logic [15:0] dropped_q, dropped_d;

   logic [15:0] ev_session;
   logic [15:0] ev_length;
   logic [31:0] ev_ip;
   logic        ev_closed;
   logic        unused_event_bits;

   logic        ev_hs;
   logic        rr_hs;
   logic        meta_hs;
   logic        rx_dec;
   logic        chunk_done;
   logic [15:0] chunk_next;

   assign ev_session        = event_data[15:0];
   assign ev_length         = event_data[31:16];
   assign ev_ip             = event_data[63:32];
   assign ev_closed         = event_data[80];
   assign unused_event_bits = ^{event_data[87:81], event_data[79:64]};

   assign event_ready = (state_q == S_IDLE) && !rst;
   assign ev_hs       = event_valid && event_ready;
   assign rr_hs       = readreq_valid_q && readreq_ready;
   assign meta_hs     = meta_valid_q && meta_ready;
   assign rx_dec      = rx_done && (outstanding_q != 8'd0);
   assign chunk_next  = (remaining_q > MAX_CHUNK) ? MAX_CHUNK : remaining_q;

   always_comb begin
      state_d         = state_q;
      session_d       = session_q;
      ip_d            = ip_q;
      remaining_d     = remaining_q;
      chunk_d         = chunk_q;
      readreq_valid_d = readreq_valid_q;
      meta_valid_d    = meta_valid_q;
      readreq_data_d  = readreq_data_q;
      meta_data_d     = meta_data_q;
      dropped_d       = dropped_q;
      chunk_done      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (ev_hs) begin
               session_d = ev_session;
               ip_d      = ev_ip;
               if ((ev_length == 16'd0) || ev_closed) begin
                  dropped_d = dropped_q + 16'd1;
               end else begin
                  remaining_d = ev_length;
                  state_d     = S_LOAD;
               end
            end
         end

         S_LOAD: begin
            // Credit is judged on the registered count; the pending request is
            // not yet counted, but only one request is ever in flight here.
            if (outstanding_q < MAX_OUT) begin
               chunk_d         = chunk_next;
               readreq_data_d  = {chunk_next, session_q};
               meta_data_d     = {ip_q, chunk_next, session_q};
               readreq_valid_d = 1'b1;
               meta_valid_d    = 1'b1;
               state_d         = S_ISSUE;
            end
         end

         S_ISSUE: begin
            if (rr_hs) begin
               readreq_valid_d = 1'b0;
            end
            if (meta_hs) begin
               meta_valid_d = 1'b0;
            end
            if (meta_hs && (rr_hs || !readreq_valid_q)) begin
               chunk_done = 1'b1;
            end else if (meta_hs) begin
               state_d = S_WAIT;
            end
         end

         S_WAIT: begin
            if (rr_hs) begin
               readreq_valid_d = 1'b0;
               chunk_done      = 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (chunk_done) begin
         remaining_d = remaining_q - chunk_q;
         state_d     = (remaining_q == chunk_q) ? S_IDLE : S_LOAD;
      end
   end

   // A request accepted in the same cycle as a drain leaves the count unchanged.
   always_comb begin
      outstanding_d = outstanding_q;
      case ({rr_hs, rx_dec})
         2'b10:   outstanding_d = outstanding_q + 8'd1;
         2'b01:   outstanding_d = outstanding_q - 8'd1;
         default: outstanding_d = outstanding_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= S_IDLE;
         session_q       <= 16'd0;
         ip_q            <= 32'd0;
         remaining_q     <= 16'd0;
         chunk_q         <= 16'd0;
         readreq_valid_q <= 1'b0;
         meta_valid_q    <= 1'b0;
         readreq_data_q  <= 32'd0;
         meta_data_q     <= 64'd0;
         outstanding_q   <= 8'd0;
         dropped_q       <= 16'd0;
      end else begin
         state_q         <= state_d;
         session_q       <= session_d;
         ip_q            <= ip_d;
         remaining_q     <= remaining_d;
         chunk_q         <= chunk_d;
         readreq_valid_q <= readreq_valid_d;
         meta_valid_q    <= meta_valid_d;
         readreq_data_q  <= readreq_data_d;
         meta_data_q     <= meta_data_d;
         outstanding_q   <= outstanding_d;
         dropped_q       <= dropped_d;
      end
   end

   assign readreq_valid = readreq_valid_q;
   assign readreq_data  = readreq_data_q;
   assign meta_valid    = meta_valid_q;
   assign meta_data     = meta_data_q;
   assign outstanding   = outstanding_q;
   assign dropped_cnt   = dropped_q;

endmodule

// File: tb/tb_tcp_rx_read_scheduler.sv
// Directed and randomized checks of tcp_rx_read_scheduler against a chunk-splitting
// reference model built from queues of expected requests and metadata words.
module tb_tcp_rx_read_scheduler;

   localparam int unsigned MAXR = 1024;
   localparam int unsigned MAXO = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        event_valid;
   logic        event_ready;
   logic [87:0] event_data;
   logic        readreq_valid;
   logic        readreq_ready;
   logic [31:0] readreq_data;
   logic        meta_valid;
   logic        meta_ready;
   logic [63:0] meta_data;
   logic        rx_done;
   logic [7:0]  outstanding;
   logic [15:0] dropped_cnt;

   int checks = 0;
   int errors = 0;

   logic [31:0] act_rr[$];
   logic [63:0] act_meta[$];
   logic [31:0] exp_rr[$];
   logic [63:0] exp_meta[$];
   int          rr_rd = 0;
   int          meta_rd = 0;
   int          rr_base = 0;
   int          drained = 0;
   logic [15:0] m_drop = 16'd0;
   logic [7:0]  max_seen = 8'd0;

   tcp_rx_read_scheduler #(
      .MAX_READ_BYTES (MAXR),
      .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .event_valid  (event_valid),
      .event_ready  (event_ready),
      .event_data   (event_data),
      .readreq_valid(readreq_valid),
      .readreq_ready(readreq_ready),
      .readreq_data (readreq_data),
      .meta_valid   (meta_valid),
      .meta_ready   (meta_ready),
      .meta_data    (meta_data),
      .rx_done      (rx_done),
      .outstanding  (outstanding),
      .dropped_cnt  (dropped_cnt)
   );

   always #5 clk = ~clk;

   // Inputs only change 1 time unit after a rising edge, so the negedge view
   // equals what the next rising edge will sample.
   always @(negedge clk) begin
      if (!rst) begin
         if (readreq_valid && readreq_ready) act_rr.push_back(readreq_data);
         if (meta_valid && meta_ready) act_meta.push_back(meta_data);
         if (outstanding > max_seen) max_seen = outstanding;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic model_add(input logic [15:0] s, input logic [15:0] l,
                            input logic [31:0] ip, input bit cl);
      int rem;
      int c;
      if (l == 16'd0 || cl) begin
         m_drop = m_drop + 16'd1;
      end else begin
         rem = int'(l);
         while (rem > 0) begin
            c = (rem > int'(MAXR)) ? int'(MAXR) : rem;
            exp_rr.push_back({16'(c), s});
            exp_meta.push_back({ip, 16'(c), s});
            rem = rem - c;
         end
      end
   endtask

   task automatic rand_drive();
      readreq_ready = ($urandom_range(0, 3) != 0);
      meta_ready    = ($urandom_range(0, 3) != 0);
      if ((act_rr.size() - rr_base) > drained && $urandom_range(0, 2) == 0) begin
         rx_done = 1'b1;
         drained++;
      end else begin
         rx_done = 1'b0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] s, input logic [15:0] l, input logic [31:0] ip,
                       input bit cl, input bit rnd);
      int n = 0;
      event_valid = 1'b1;
      event_data  = {7'd0, cl, 16'(~s), ip, l, s};
      while (!event_ready && n < 3000) begin
         if (rnd) rand_drive();
         tick();
         n++;
      end
      check("send_accept", 64'(event_ready), 64'd1);
      if (rnd) rand_drive();
      tick();
      event_valid = 1'b0;
      rx_done     = 1'b0;
      model_add(s, l, ip, cl);
   endtask

   task automatic wait_idle(input bit rnd, input string tag);
      int n = 0;
      while (!event_ready && n < 3000) begin
         if (rnd) rand_drive();
         tick();
         n++;
      end
      rx_done = 1'b0;
      check({tag, "_idle"}, 64'(event_ready), 64'd1);
   endtask

   task automatic pulse_rx();
      rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
      drained++;
   endtask

   task automatic compare_all(input string tag);
      logic [31:0] er;
      logic [63:0] em;
      check({tag, "_rr_count"}, 64'(act_rr.size() - rr_rd), 64'(exp_rr.size()));
      while (exp_rr.size() > 0 && rr_rd < act_rr.size()) begin
         er = exp_rr.pop_front();
         check({tag, "_rr"}, 64'(act_rr[rr_rd]), 64'(er));
         rr_rd++;
      end
      exp_rr.delete();
      rr_rd = act_rr.size();
      check({tag, "_meta_count"}, 64'(act_meta.size() - meta_rd), 64'(exp_meta.size()));
      while (exp_meta.size() > 0 && meta_rd < act_meta.size()) begin
         em = exp_meta.pop_front();
         check({tag, "_meta"}, act_meta[meta_rd], em);
         meta_rd++;
      end
      exp_meta.delete();
      meta_rd = act_meta.size();
   endtask

   initial begin
      int n;
      logic [15:0] rl;
      rst           = 1'b1;
      event_valid   = 1'b0;
      event_data    = 88'd0;
      readreq_ready = 1'b0;
      meta_ready    = 1'b0;
      rx_done       = 1'b0;
      repeat (3) tick();

      // Reset state
      check("rst_event_ready", 64'(event_ready), 64'd0);
      check("rst_rr_valid", 64'(readreq_valid), 64'd0);
      check("rst_meta_valid", 64'(meta_valid), 64'd0);
      check("rst_rr_data", 64'(readreq_data), 64'd0);
      check("rst_meta_data", meta_data, 64'd0);
      check("rst_outstanding", 64'(outstanding), 64'd0);
      check("rst_dropped", 64'(dropped_cnt), 64'd0);
      rst = 1'b0;
      #1;
      check("idle_event_ready", 64'(event_ready), 64'd1);

      // Single chunk, latency and content
      readreq_ready = 1'b1;
      meta_ready    = 1'b1;
      send(16'h0005, 16'h0200, 32'h0A000001, 1'b0, 1'b0);
      check("t1_lat0_valid", 64'(readreq_valid), 64'd0);
      check("t1_busy", 64'(event_ready), 64'd0);
      tick();
      check("t1_rr_valid", 64'(readreq_valid), 64'd1);
      check("t1_meta_valid", 64'(meta_valid), 64'd1);
      check("t1_rr_data", 64'(readreq_data), 64'h02000005);
      check("t1_meta_data", meta_data, 64'h0A00000102000005);
      wait_idle(1'b0, "t1");
      check("t1_outstanding", 64'(outstanding), 64'd1);
      compare_all("t1");
      pulse_rx();
      check("t1_drained", 64'(outstanding), 64'd0);
      rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
      check("sat_zero", 64'(outstanding), 64'd0);

      // 2500 bytes -> 1024, 1024, 452 with credit stall on the third
      send(16'h0011, 16'd2500, 32'hC0A80002, 1'b0, 1'b0);
      n = 0;
      while ((act_rr.size() - rr_rd) < 2 && n < 200) begin
         tick();
         n++;
      end
      repeat (3) tick();
      check("t2_two_issued", 64'(act_rr.size() - rr_rd), 64'd2);
      check("t2_busy", 64'(event_ready), 64'd0);
      check("t2_outstanding", 64'(outstanding), 64'd2);
      check("t2_stalled", 64'(readreq_valid), 64'd0);
      pulse_rx();
      wait_idle(1'b0, "t2");
      check("t2_out_end", 64'(outstanding), 64'd2);
      compare_all("t2");
      pulse_rx();
      pulse_rx();

      // Drops: zero length, then closed session
      send(16'h0001, 16'd0, 32'h01020304, 1'b0, 1'b0);
      check("t3_ready_a", 64'(event_ready), 64'd1);
      check("t3_drop_a", 64'(dropped_cnt), 64'(m_drop));
      send(16'h0002, 16'd64, 32'h01020305, 1'b1, 1'b0);
      check("t3_ready_b", 64'(event_ready), 64'd1);
      check("t3_drop_b", 64'(dropped_cnt), 64'd2);
      repeat (3) tick();
      check("t3_no_rr", 64'(readreq_valid), 64'd0);
      check("t3_no_meta", 64'(meta_valid), 64'd0);
      compare_all("t3");

      // Credit limit of 2 with three 64-byte notifications
      send(16'h0021, 16'd64, 32'h0B000001, 1'b0, 1'b0);
      wait_idle(1'b0, "t4a");
      send(16'h0022, 16'd64, 32'h0B000002, 1'b0, 1'b0);
      wait_idle(1'b0, "t4b");
      send(16'h0023, 16'd64, 32'h0B000003, 1'b0, 1'b0);
      repeat (4) tick();
      check("t4_busy", 64'(event_ready), 64'd0);
      check("t4_held", 64'(readreq_valid), 64'd0);
      check("t4_out_full", 64'(outstanding), 64'd2);
      check("t4_two_issued", 64'(act_rr.size() - rr_rd), 64'd2);
      pulse_rx();
      check("t4_out_dec", 64'(outstanding), 64'd1);
      tick();
      check("t4_third_valid", 64'(readreq_valid), 64'd1);
      check("t4_third_data", 64'(readreq_data), 64'h00400023);
      wait_idle(1'b0, "t4");
      check("t4_out_end", 64'(outstanding), 64'd2);
      compare_all("t4");
      pulse_rx();
      pulse_rx();

      // Meta back-pressure for 5 cycles
      readreq_ready = 1'b1;
      meta_ready    = 1'b0;
      send(16'h0031, 16'd64, 32'h0C000001, 1'b0, 1'b0);
      tick();
      for (int i = 0; i < 5; i++) begin
         check("t5_meta_valid", 64'(meta_valid), 64'd1);
         check("t5_meta_stable", meta_data, 64'h0C00000100400031);
         if (i > 0) check("t5_rr_once", 64'(readreq_valid), 64'd0);
         tick();
      end
      meta_ready = 1'b1;
      wait_idle(1'b0, "t5");
      compare_all("t5");

      // Readreq back-pressure with meta already taken
      readreq_ready = 1'b0;
      send(16'h0032, 16'd128, 32'h0C000002, 1'b0, 1'b0);
      tick();
      for (int i = 0; i < 4; i++) begin
         check("t5w_rr_valid", 64'(readreq_valid), 64'd1);
         check("t5w_rr_stable", 64'(readreq_data), 64'h00800032);
         if (i > 0) check("t5w_meta_once", 64'(meta_valid), 64'd0);
         tick();
      end
      readreq_ready = 1'b1;
      wait_idle(1'b0, "t5w");
      check("t5w_outstanding", 64'(outstanding), 64'd2);
      compare_all("t5w");
      pulse_rx();

      // Reset while issuing the first chunk of a 3-chunk notification
      readreq_ready = 1'b0;
      meta_ready    = 1'b0;
      send(16'h0041, 16'd3000, 32'h0D000001, 1'b0, 1'b0);
      tick();
      check("t6_pre_valid", 64'(readreq_valid), 64'd1);
      rst = 1'b1;
      tick();
      check("t6_rr_valid", 64'(readreq_valid), 64'd0);
      check("t6_meta_valid", 64'(meta_valid), 64'd0);
      check("t6_outstanding", 64'(outstanding), 64'd0);
      check("t6_dropped", 64'(dropped_cnt), 64'd0);
      check("t6_ready_in_rst", 64'(event_ready), 64'd0);
      rst = 1'b0;
      #1;
      check("t6_ready_after", 64'(event_ready), 64'd1);
      exp_rr.delete();
      exp_meta.delete();
      rr_rd   = act_rr.size();
      meta_rd = act_meta.size();
      rr_base = act_rr.size();
      drained = 0;
      m_drop  = 16'd0;
      readreq_ready = 1'b1;
      meta_ready    = 1'b1;
      send(16'h0051, 16'd1100, 32'h0E000001, 1'b0, 1'b0);
      wait_idle(1'b0, "t6");
      check("t6_out_fresh", 64'(outstanding), 64'd2);
      compare_all("t6");

      // Randomized notifications, ready throttling and drains
      for (int k = 0; k < 30; k++) begin
         case ($urandom_range(0, 5))
            0:       rl = 16'd0;
            1:       rl = 16'd1024;
            2:       rl = 16'd2048;
            default: rl = 16'($urandom_range(1, 3000));
         endcase
         send(16'($urandom), rl, $urandom, ($urandom_range(0, 7) == 0), 1'b1);
      end
      wait_idle(1'b1, "rnd");
      readreq_ready = 1'b1;
      meta_ready    = 1'b1;
      compare_all("rnd");
      check("rnd_dropped", 64'(dropped_cnt), 64'(m_drop));
      n = 0;
      while ((act_rr.size() - rr_base) > drained && n < 500) begin
         pulse_rx();
         n++;
      end
      tick();
      check("rnd_out_zero", 64'(outstanding), 64'd0);
      check("rnd_credit_cap", 64'(max_seen <= 8'(MAXO)), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
